// File: rtl/memview_pkg.sv
// rtl/memview_pkg.sv - shared types and constants for the board memory viewer
//
// Contents:
//   memview_state_t  controller state (RUN, READ, SHOW), 2 bits
//   word_t           32-bit memory word
//   baddr_t          16-bit byte address as seen on the switches and displays
//   WORD_ALIGN_MASK  clears the byte offset of a byte address
package memview_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        READ = 2'd1,
        SHOW = 2'd2
    } memview_state_t;

    typedef logic [31:0] word_t;
    typedef logic [15:0] baddr_t;

    localparam baddr_t WORD_ALIGN_MASK = 16'hFFFC;

endpackage

// File: rtl/memview_step_timer.sv
// rtl/memview_step_timer.sv - auto-scan step timer, one-cycle tick every AUTO_DIV enabled cycles
//
// Ports:
//   CLK   in   system clock
//   nRST  in   asynchronous active-low reset
//   en    in   count enable
//   clr   in   synchronous clear, wins over en
//   tick  out  high for the one cycle the count sits at AUTO_DIV-1
module memview_step_timer #(
    parameter int AUTO_DIV = 25000000
) (
    input  logic CLK,
    input  logic nRST,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(AUTO_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TERM);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/board_mem_viewer.sv
// rtl/board_mem_viewer.sv - post-halt memory inspection sequencer between board I/O and the system testbench port
//
// Ports:
//   CLK, nRST        clock, asynchronous active-low reset
//   halt             CPU halted
//   sw_addr[15:0]    manual byte address from the switches
//   mode_auto        1 = auto-scan, 0 = manual
//   step_n           step key, active-low
//   load[31:0]       read data from the system
//   tb_ctrl          testbench owns memory
//   ren              read request
//   addr[31:0]       read address, {16'b0, cur_addr}
//   shown_word[31:0] last captured word
//   shown_addr[15:0] address of shown_word
//   word_valid       shown_word is current
//
// Build option MEMVIEW_SYNC_EN: when defined, sw_addr, mode_auto and step_n
// pass through 2-flop synchronizers (2 cycles extra input latency).
module board_mem_viewer
    import memview_pkg::*;
#(
    parameter int RD_LAT    = 2,
    parameter int AUTO_DIV  = 25000000,
    parameter int ADDR_STEP = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic [15:0] sw_addr,
    input  logic        mode_auto,
    input  logic        step_n,
    input  logic [31:0] load,
    output logic        tb_ctrl,
    output logic        ren,
    output logic [31:0] addr,
    output logic [31:0] shown_word,
    output logic [15:0] shown_addr,
    output logic        word_valid
);

    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(RD_LAT - 1);
    localparam baddr_t STEP = baddr_t'(ADDR_STEP);

    baddr_t sw_i;
    logic   auto_i;
    logic   step_i;

`ifdef MEMVIEW_SYNC_EN
    baddr_t sw_s1, sw_s2;
    logic   auto_s1, auto_s2, step_s1, step_s2;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            auto_s1 <= 1'b0;
            auto_s2 <= 1'b0;
            step_s1 <= 1'b1;
            step_s2 <= 1'b1;
        end else begin
            sw_s1   <= sw_addr;
            sw_s2   <= sw_s1;
            auto_s1 <= mode_auto;
            auto_s2 <= auto_s1;
            step_s1 <= step_n;
            step_s2 <= step_s1;
        end
    end

    assign sw_i   = sw_s2;
    assign auto_i = auto_s2;
    assign step_i = step_s2;
`else
    assign sw_i   = sw_addr;
    assign auto_i = mode_auto;
    assign step_i = step_n;
`endif

    memview_state_t state, state_nx;
    baddr_t         cur_addr, cur_nx;
    logic [WCW-1:0] wcnt, wcnt_nx;
    logic           issued, issued_nx;
    logic           capture;
    logic           step_q;
    logic           press;
    logic           tick;
    logic           tmr_en;

    // Falling edge of the step key, one cycle per press.
    assign press = step_q && !step_i;

    assign tmr_en = (state == SHOW) && auto_i;

    memview_step_timer #(.AUTO_DIV(AUTO_DIV)) u_step_timer (
        .CLK  (CLK),
        .nRST (nRST),
        .en   (tmr_en),
        .clr  (!tmr_en),
        .tick (tick)
    );

    assign tb_ctrl    = (state != RUN);
    assign ren        = (state == READ);
    assign word_valid = (state == SHOW);
    assign addr       = {16'b0, cur_addr};

    // The first READ cycle only issues ren; the wait counter starts on the
    // following cycle so the capture lands RD_LAT cycles after the request.
    always_comb begin
        state_nx = state;
        cur_nx   = cur_addr;
        wcnt_nx  = wcnt;
        capture  = 1'b0;
        case (state)
            RUN: begin
                wcnt_nx = '0;
                if (halt) begin
                    state_nx = READ;
                    cur_nx   = auto_i ? (sw_i & WORD_ALIGN_MASK) : sw_i;
                end
            end
            READ: begin
                if (!halt) begin
                    state_nx = RUN;
                    wcnt_nx  = '0;
                end else if (issued) begin
                    if (wcnt == WLAST) begin
                        capture  = 1'b1;
                        wcnt_nx  = '0;
                        state_nx = SHOW;
                    end else begin
                        wcnt_nx = wcnt + 1'b1;
                    end
                end
            end
            SHOW: begin
                if (!halt) begin
                    state_nx = RUN;
                end else if (auto_i) begin
                    // A press coinciding with the timer tick still yields one step.
                    if (tick || press) begin
                        cur_nx   = shown_addr + STEP;
                        state_nx = READ;
                    end
                end else if (sw_i != shown_addr) begin
                    cur_nx   = sw_i;
                    state_nx = READ;
                end
            end
            default: state_nx = RUN;
        endcase
        issued_nx = (state == READ) && (state_nx == READ);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cur_addr   <= '0;
            wcnt       <= '0;
            issued     <= 1'b0;
            step_q     <= 1'b1;
            shown_word <= '0;
            shown_addr <= '0;
        end else begin
            cur_addr <= cur_nx;
            wcnt     <= wcnt_nx;
            issued   <= issued_nx;
            step_q   <= step_i;
            if (capture) begin
                shown_word <= load;
                shown_addr <= cur_addr;
            end
        end
    end

endmodule
